// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
package alu_share_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned LAT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SEL3_A    = 2'b00;
  localparam logic [1:0] SEL3_ALU  = 2'b01;
  localparam logic [1:0] SEL3_B    = 2'b10;
  localparam logic [1:0] SEL3_ZERO = 2'b11;

  // One ALU operation as presented by a requester; sel = {se1, se2, se3[1:0]}.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  sel;
  } alu_req_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, response and ALU-datapath signals of the ALU sharing arbiter.
interface alu_share_arb_if;
  import alu_share_arb_pkg::*;

  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [OP_W-1:0]   req0_op;
  logic [SEL_W-1:0]  req0_sel;

  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [OP_W-1:0]   req1_op;
  logic [SEL_W-1:0]  req1_sel;

  logic              rsp0_valid, rsp0_ready;
  logic              rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_data;

  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_se1, alu_se2;
  logic [1:0]        alu_se3;
  logic [DATA_W-1:0] alu_result;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_op, req1_sel,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    output alu_a, alu_b, alu_op, alu_se1, alu_se2, alu_se3
  );

  // Requester / datapath side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_sel,
    output req1_valid, req1_a, req1_b, req1_op, req1_sel,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    input  alu_a, alu_b, alu_op, alu_se1, alu_se2, alu_se3
  );

endinterface

// File: rtl/alu_share_arb_rr_grant2.sv
// Combinational 2-way grant; round-robin on last_grant, or requester 0
// always first when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_c
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant_c = valid;
    if (valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_c = 2'b01;
`else
      grant_c = last_grant ? 2'b01 : 2'b10;
`endif
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU datapath between two requesters: grant, drive operands
// for ALU_LAT cycles, capture result, return it. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  alu_share_arb_if.slave bus
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  alu_req_t          opr_q, opr_d;
  logic [1:0]        se3_q, se3_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        rspv_q, rspv_d;
  logic [1:0]        grant_c, ready_c;
  alu_req_t          req0_p, req1_p;

  assign req0_p = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op, sel: bus.req0_sel};
  assign req1_p = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op, sel: bus.req1_sel};

  rr_grant2 u_grant (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_q),
    .grant_c    (grant_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    opr_d   = opr_q;
    se3_d   = se3_q;
    data_d  = data_q;
    rspv_d  = rspv_q;
    ready_c = 2'b00;
    unique case (state_q)
      IDLE: begin
        ready_c = grant_c & {2{~rst}};
        if (|grant_c) begin
          owner_d = grant_c[1];
          last_d  = grant_c[1];
          opr_d   = grant_c[1] ? req1_p : req0_p;
          se3_d   = opr_d.sel[1:0];
          lat_d   = LAT_W'(ALU_LAT - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (lat_q == '0) begin
          data_d  = bus.alu_result;
          rspv_d  = owner_q ? 2'b10 : 2'b01;
          se3_d   = SEL3_ZERO;
          state_d = RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          rspv_d  = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      lat_q   <= '0;
      opr_q   <= '0;
      se3_q   <= SEL3_ZERO;
      data_q  <= '0;
      rspv_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      opr_q   <= opr_d;
      se3_q   <= se3_d;
      data_q  <= data_d;
      rspv_q  <= rspv_d;
    end
  end

  // Handshake readiness is decided in the same cycle the request is seen
  assign bus.req0_ready = ready_c[0];
  assign bus.req1_ready = ready_c[1];
  assign bus.rsp0_valid = rspv_q[0];
  assign bus.rsp1_valid = rspv_q[1];
  assign bus.rsp_data   = data_q;
  assign bus.alu_a      = opr_q.a;
  assign bus.alu_b      = opr_q.b;
  assign bus.alu_op     = opr_q.op;
  assign bus.alu_se1    = opr_q.sel[3];
  assign bus.alu_se2    = opr_q.sel[2];
  assign bus.alu_se3    = se3_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: two instances (ALU_LAT=1 and 3), a cycle-count
// based transaction model checked every cycle, and directed scenarios.
module tb_alu_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0] vld  [2];
  logic [1:0] rrdy [2];
  logic [7:0] in_a [2][2];
  logic [7:0] in_b [2][2];
  logic [3:0] in_op[2][2];
  logic [3:0] in_sel[2][2];
  logic [7:0] alu_val[2];

  logic [1:0] rdy[2], rv[2];
  logic [7:0] rd[2], oa[2], ob[2];
  logic [3:0] oop[2];
  logic       os1[2], os2[2];
  logic [1:0] os3[2];

  function automatic logic [7:0] dp(input logic [1:0] s, input logic [7:0] a, b, f);
    case (s)
      2'b00:   return a;
      2'b01:   return f;
      2'b10:   return b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  alu_share_arb_if bus[2] ();

  alu_share_arb #(.ALU_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
  alu_share_arb #(.ALU_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus[1]));

  for (genvar g = 0; g < 2; g++) begin : g_conn
    assign bus[g].req0_valid = vld[g][0];
    assign bus[g].req0_a     = in_a[g][0];
    assign bus[g].req0_b     = in_b[g][0];
    assign bus[g].req0_op    = in_op[g][0];
    assign bus[g].req0_sel   = in_sel[g][0];
    assign bus[g].req1_valid = vld[g][1];
    assign bus[g].req1_a     = in_a[g][1];
    assign bus[g].req1_b     = in_b[g][1];
    assign bus[g].req1_op    = in_op[g][1];
    assign bus[g].req1_sel   = in_sel[g][1];
    assign bus[g].rsp0_ready = rrdy[g][0];
    assign bus[g].rsp1_ready = rrdy[g][1];
    // Datapath stand-in: result mux driven by the DUT's own select lines
    assign bus[g].alu_result = dp(bus[g].alu_se3, bus[g].alu_a, bus[g].alu_b, alu_val[g]);
    assign rdy[g] = {bus[g].req1_ready, bus[g].req0_ready};
    assign rv[g]  = {bus[g].rsp1_valid, bus[g].rsp0_valid};
    assign rd[g]  = bus[g].rsp_data;
    assign oa[g]  = bus[g].alu_a;
    assign ob[g]  = bus[g].alu_b;
    assign oop[g] = bus[g].alu_op;
    assign os1[g] = bus[g].alu_se1;
    assign os2[g] = bus[g].alu_se2;
    assign os3[g] = bus[g].alu_se3;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [1:0] v, input bit last);
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return last ? 0 : 1;
`endif
    end
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // Model: an op is busy from its accept edge; k counts cycles since accept
  bit         m_busy[2], m_own[2], m_last[2];
  int         m_k[2];
  logic [7:0] m_a[2], m_b[2], m_data[2];
  logic [3:0] m_op[2], m_sel[2];
  int         gq0[$], gq1[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_own[d] = 0; m_last[d] = 1; m_k[d] = 0;
      m_a[d] = 0; m_b[d] = 0; m_op[d] = 0; m_sel[d] = 0; m_data[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w, lat;
      logic [1:0] e_rdy, e_rv, e_s3;
      lat   = lat_of(d);
      w     = winner(vld[d], m_last[d]);
      e_rdy = 2'b00;
      e_rv  = 2'b00;
      if (!m_busy[d] && !rst && w >= 0) e_rdy[w] = 1'b1;
      if (m_busy[d] && m_k[d] >= lat) e_rv[m_own[d]] = 1'b1;
      e_s3 = (m_busy[d] && m_k[d] < lat) ? m_sel[d][1:0] : 2'b11;
      chk($sformatf("ready[%0d]", d), 32'(rdy[d]), 32'(e_rdy));
      chk($sformatf("rsp_valid[%0d]", d), 32'(rv[d]), 32'(e_rv));
      chk($sformatf("rsp_data[%0d]", d), 32'(rd[d]), 32'(m_data[d]));
      chk($sformatf("alu_a[%0d]", d), 32'(oa[d]), 32'(m_a[d]));
      chk($sformatf("alu_b[%0d]", d), 32'(ob[d]), 32'(m_b[d]));
      chk($sformatf("alu_op[%0d]", d), 32'(oop[d]), 32'(m_op[d]));
      chk($sformatf("alu_se12[%0d]", d), 32'({os1[d], os2[d]}), 32'(m_sel[d][3:2]));
      chk($sformatf("alu_se3[%0d]", d), 32'(os3[d]), 32'(e_s3));
      if (rst) begin
        m_busy[d] = 0; m_last[d] = 1; m_data[d] = 0;
        m_a[d] = 0; m_b[d] = 0; m_op[d] = 0; m_sel[d] = 0;
      end else if (!m_busy[d]) begin
        if (w >= 0) begin
          m_busy[d] = 1; m_k[d] = 0; m_own[d] = w[0]; m_last[d] = w[0];
          m_a[d] = in_a[d][w]; m_b[d] = in_b[d][w];
          m_op[d] = in_op[d][w]; m_sel[d] = in_sel[d][w];
          if (d == 0) gq0.push_back(w); else gq1.push_back(w);
        end
      end else if (m_k[d] < lat) begin
        if (m_k[d] == lat - 1) m_data[d] = dp(m_sel[d][1:0], m_a[d], m_b[d], alu_val[d]);
        m_k[d]++;
      end else if (rrdy[d][m_own[d]]) begin
        m_busy[d] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, r, input logic [7:0] a, b, input logic [3:0] op, sel);
    in_a[d][r] = a; in_b[d][r] = b; in_op[d][r] = op; in_sel[d][r] = sel;
  endtask

  // Hold valid until accepted; returns 1 time unit after the accepting edge
  task automatic issue(input int d, r, input logic [7:0] a, b, input logic [3:0] op, sel);
    bit got = 0;
    int n = 0;
    set_req(d, r, a, b, op, sel);
    vld[d][r] = 1'b1;
    while (!got && n < 30) begin
      @(negedge clk);
      got = rdy[d][r];
      tick();
      n++;
    end
    vld[d][r] = 1'b0;
    chk("issue_accepted", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int d, r, output logic [7:0] data);
    bit got = 0;
    int n = 0;
    data = 8'hxx;
    while (!got && n < 30) begin
      @(negedge clk);
      got = rv[d][r];
      if (got) data = rd[d];
      n++;
    end
    chk("rsp_arrived", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] data;
    int base, n;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 2'b00; rrdy[d] = 2'b11; alu_val[d] = 8'h00;
      for (int r = 0; r < 2; r++) set_req(d, r, 8'h00, 8'h00, 4'h0, 4'h0);
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_se3", 32'(os3[0]), 32'h3);
    chk("reset_rsp_data", 32'(rd[0]), 32'h0);
    chk("reset_rsp_valid", 32'(rv[0]), 32'h0);
    tick();

    // Single op, LAT=1: se3=01 for one cycle, result one cycle after accept
    alu_val[0] = 8'h08;
    issue(0, 0, 8'h05, 8'h03, 4'h1, 4'b1101);
    @(negedge clk);
    chk("t1_se3_exec", 32'(os3[0]), 32'h1);
    tick();
    @(negedge clk);
    chk("t1_rsp0_valid", 32'(rv[0]), 32'h1);
    chk("t1_rsp_data", 32'(rd[0]), 32'h08);
    chk("t1_se3_after", 32'(os3[0]), 32'h3);
    tick();

    // se3=11 forces zero regardless of operands
    alu_val[0] = 8'h5A;
    issue(0, 1, 8'hFF, 8'hAA, 4'h7, 4'b0011);
    wait_rsp(0, 1, data);
    chk("t6_zero_result", 32'(data), 32'h00);
    tick();

    // Contested: four back-to-back ops with both requesters valid
    base = gq0.size();
    set_req(0, 0, 8'h10, 8'h01, 4'h2, 4'b0000);
    set_req(0, 1, 8'h20, 8'h2B, 4'h3, 4'b0010);
    vld[0] = 2'b11;
    n = 0;
    while (gq0.size() < base + 4 && n < 40) begin
      tick();
      n++;
    end
    vld[0] = 2'b00;
    chk("t2_ops", 32'(gq0.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk($sformatf("t2_grant%0d", i), 32'(gq0[base + i]), 32'd0);
`else
      chk($sformatf("t2_grant%0d", i), 32'(gq0[base + i]), 32'(i % 2));
`endif
    end
    repeat (3) tick();

    // Response back-pressure on requester 1 while requester 0 waits
    rrdy[0][1] = 1'b0;
    alu_val[0] = 8'h42;
    issue(0, 1, 8'h01, 8'h02, 4'h3, 4'b0001);
    set_req(0, 0, 8'h77, 8'h66, 4'h4, 4'b0000);
    vld[0][0] = 1'b1;
    wait_rsp(0, 1, data);
    chk("t3_rsp_data", 32'(data), 32'h42);
    alu_val[0] = 8'h99;
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("t3_hold_valid", 32'(rv[0][1]), 32'h1);
      chk("t3_hold_data", 32'(rd[0]), 32'h42);
      chk("t3_req0_blocked", 32'(rdy[0][0]), 32'h0);
    end
    tick();
    rrdy[0][1] = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_req0_granted", 32'(rdy[0][0]), 32'h1);
    tick();
    vld[0][0] = 1'b0;
    repeat (3) tick();

    // LAT=3: only the value present just before the capture edge counts
    alu_val[1] = 8'h11;
    issue(1, 0, 8'hA0, 8'hB0, 4'h5, 4'b1001);
    tick(); alu_val[1] = 8'h22;
    tick(); alu_val[1] = 8'h33;
    @(negedge clk);
    chk("t4_not_yet", 32'(rv[1]), 32'h0);
    tick(); alu_val[1] = 8'h44;
    @(negedge clk);
    chk("t4_rsp_valid", 32'(rv[1]), 32'h1);
    chk("t4_rsp_data", 32'(rd[1]), 32'h33);
    tick();
    repeat (2) tick();

    // Reset in the middle of EXEC discards the op
    alu_val[1] = 8'h55;
    issue(1, 0, 8'hC3, 8'h3C, 4'h6, 4'b0101);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(rv[1]), 32'h0);
    chk("t5_se3", 32'(os3[1]), 32'h3);
    chk("t5_rsp_data", 32'(rd[1]), 32'h00);
    chk("t5_alu_a", 32'(oa[1]), 32'h00);
    repeat (4) tick();
    base = gq1.size();
    set_req(1, 0, 8'h01, 8'h01, 4'h1, 4'b0000);
    set_req(1, 1, 8'h02, 8'h02, 4'h1, 4'b0000);
    vld[1] = 2'b11;
    @(negedge clk);
    chk("t5_req0_wins", 32'(rdy[1]), 32'h1);
    tick();
    vld[1] = 2'b00;
    chk("t5_model_grant", 32'(gq1.size() - base), 32'd1);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
